instr_fetch_unit: RTL and testbench

- Consumer end of the program-counter interface.
- Takes the word address on pc, issues one read to instruction memory and waits for the data.
- Presents the fetched word plus its address to decode through a valid/ready handshake.
- Tells the PC when its address has been taken (pc_advance) and discards in-flight fetches on a taken branch (flush).

---
 rtl/instr_fetch_unit.sv | 128 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: single-outstanding instruction fetcher.
// Takes the word address on pc, issues one read to instruction memory,
// buffers the returned word with its address, and hands it to decode over
// a valid/ready handshake. A flush (taken branch) discards any pending fetch
// and any buffered instruction.
// Optional build macro: FETCH_STALL_CNT_EN adds a saturating 32-bit
// stall_cnt output counting cycles lost to memory (ungranted request or
// waiting for read data).
module instr_fetch_unit #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    output logic          pc_advance,
    input  logic          flush,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [DW-1:0] imem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_FULL = 2'd3
    } state_t;

    state_t        state_q;
    logic [AW-1:0] req_pc_q;
    logic          drop_q;
    logic          instr_valid_q;
    logic [DW-1:0] instr_q;
    logic [AW-1:0] instr_pc_q;
    logic          req_d;
    logic          grant_d;

    // Request is gated combinationally by flush so a branch in the same cycle
    // never lets a stale address reach memory or advance the PC.
    assign req_d      = (state_q == S_REQ) && !flush;
    assign grant_d    = req_d && imem_gnt;
    assign imem_req   = req_d;
    assign imem_addr  = pc;
    assign pc_advance = grant_d;

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;

    // Fetch FSM: one request in flight, single-entry output buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            req_pc_q      <= '0;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (grant_d) begin
                        req_pc_q <= pc;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (drop_q || flush) begin
                            // Response belongs to a flushed fetch; throw it away.
                            drop_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else begin
                            instr_q       <= imem_rdata;
                            instr_pc_q    <= req_pc_q;
                            instr_valid_q <= 1'b1;
                            state_q       <= S_FULL;
                        end
                    end else if (flush) begin
                        // Remember to discard the response still on its way.
                        drop_q <= 1'b1;
                    end
                end
                S_FULL: begin
                    if (instr_ready || flush) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= S_REQ;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt_q;
    logic        stall_d;

    assign stall_d   = (req_d && !imem_gnt) || ((state_q == S_WAIT) && !imem_rvalid);
    assign stall_cnt = stall_cnt_q;

    // Saturating count of cycles spent waiting on instruction memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. Memory handshake is driven cycle by
// cycle; inputs change 1 ns after the rising edge and outputs are checked
// 1 ns after that.
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc;
    logic        pc_advance;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
`ifdef FETCH_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(.DW(32), .AW(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_advance  (pc_advance),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
`ifdef FETCH_STALL_CNT_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset       = 1'b0;
        pc          = 32'h10;
        flush       = 1'b0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        instr_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, 0);
        chk("rst_imem_req", imem_req, 0);
        chk("rst_pc_advance", pc_advance, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        reset = 1'b1;

        // First clock after release: IDLE -> REQ
        tick();
        chk("t1_imem_req", imem_req, 1);
        chk("t1_pc_advance", pc_advance, 1);
        chk("t1_imem_addr", imem_addr, 32'h10);
        tick();                                   // WAIT
        pc = 32'h11;
        imem_rvalid = 1'b1;
        #1;
        chk("t1_wait_req", imem_req, 0);
        chk("t1_wait_adv", pc_advance, 0);
        chk("t1_wait_valid", instr_valid, 0);
        tick();                                   // FULL
        imem_rvalid = 1'b0;
        instr_ready = 1'b0;
        #1;
        chk("t1_valid", instr_valid, 1);
        chk("t1_instr", instr, 32'hDEAD_BEEF);
        chk("t1_instr_pc", instr_pc, 32'h10);

        // Backpressure for 5 cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", instr_valid, 1);
            chk("bp_req", imem_req, 0);
            chk("bp_instr", instr, 32'hDEAD_BEEF);
            chk("bp_instr_pc", instr_pc, 32'h10);
        end
        instr_ready = 1'b1;
        tick();                                   // REQ, grant for pc 0x11
        chk("bp_rel_valid", instr_valid, 0);
        chk("bp_rel_req", imem_req, 1);
        chk("bp_rel_addr", imem_addr, 32'h11);
        chk("bp_rel_adv", pc_advance, 1);

        // Flush during WAIT, response arrives 3 cycles later and is dropped
        tick();                                   // WAIT
        pc    = 32'h40;
        flush = 1'b1;
        #1;
        chk("fw_adv", pc_advance, 0);
        chk("fw_req", imem_req, 0);
        tick();
        flush = 1'b0;
        #1;
        chk("fw_valid_a", instr_valid, 0);
        tick();
        chk("fw_valid_b", instr_valid, 0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111;
        tick();                                   // dropped -> REQ
        imem_rvalid = 1'b0;
        #1;
        chk("fw_dropped_valid", instr_valid, 0);
        chk("fw_req", imem_req, 1);
        chk("fw_addr", imem_addr, 32'h40);
        chk("fw_adv2", pc_advance, 1);
        tick();                                   // WAIT
        pc          = 32'h41;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2222;
        tick();                                   // FULL
        imem_rvalid = 1'b0;
        #1;
        chk("fw_new_valid", instr_valid, 1);
        chk("fw_new_instr", instr, 32'h2222);
        chk("fw_new_pc", instr_pc, 32'h40);

        // Flush in REQ with grant asserted
        tick();                                   // REQ
        flush = 1'b1;
        #1;
        chk("fr_req", imem_req, 0);
        chk("fr_adv", pc_advance, 0);
        tick();                                   // still REQ
        flush = 1'b0;
        #1;
        chk("fr_retry_req", imem_req, 1);
        chk("fr_retry_adv", pc_advance, 1);
        chk("fr_retry_addr", imem_addr, 32'h41);
        tick();                                   // WAIT

        // Async reset in WAIT, then stray rvalid after release
        imem_gnt = 1'b0;
        pc       = 32'h50;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", instr_valid, 0);
        chk("ar_req", imem_req, 0);
        chk("ar_adv", pc_advance, 0);
        chk("ar_instr_pc", instr_pc, 0);
        tick();
        reset       = 1'b1;
        imem_rvalid = 1'b1;                       // stray response while IDLE
        imem_rdata  = 32'h3333;
        tick();                                   // REQ, stall 1
        #1;
        chk("ar_stray_valid", instr_valid, 0);
        chk("ar_req_ungnt", imem_req, 1);
        chk("ar_adv_ungnt", pc_advance, 0);
`ifdef FETCH_STALL_CNT_EN
        chk("sc_zero", stall_cnt, 0);
`endif
        tick();                                   // stall 2
        imem_rvalid = 1'b0;
        #1;
        chk("ar_stray_valid2", instr_valid, 0);
        tick();                                   // stall 3
        tick();                                   // stall 4
        chk("sc_req_held", imem_req, 1);
        tick();                                   // grant
        imem_gnt = 1'b1;
        #1;
        chk("sc_adv", pc_advance, 1);
        tick();                                   // WAIT, no rvalid
        tick();                                   // WAIT, rvalid
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        tick();                                   // FULL
        imem_rvalid = 1'b0;
        #1;
        chk("sc_valid", instr_valid, 1);
        chk("sc_instr", instr, 32'hCAFE_F00D);
        chk("sc_instr_pc", instr_pc, 32'h50);
`ifdef FETCH_STALL_CNT_EN
        chk("sc_stall_cnt", stall_cnt, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
